image_frame_loader: RTL and testbench
=====================================

// Module: image_frame_loader
// PURPOSE
//  Upstream feeder for digit_classifier. Accepts a raster stream of 8-bit grayscale pixels over a
//  valid/ready handshake, binarises each pixel against a threshold, and packs them into a 196-bit image.
//  Once a full 14x14 frame is loaded it pulses the classifier start for one cycle.
//  It then holds the image stable and blocks new pixels until the classifier reports completion.
// PARAMETERS
//  IMG_W       14    pixels per row
//  IMG_H       14    rows per frame; NPIX = IMG_W*IMG_H = 196
//  PIX_BITS    8     grayscale pixel width
// PORTS
//  clk         in   1          clock
//  rst_n       in   1          reset, asynchronous, active-low
//  pix_in      in   PIX_BITS   grayscale pixel, unsigned
//  pix_valid   in   1          pix_in/pix_sof valid
//  pix_sof     in   1          marks first pixel of a frame (qualified by pix_valid)
//  pix_ready   out  1          loader accepts pixel this cycle
//  thresh_in   in   PIX_BITS   binarisation threshold, sampled with the SOF pixel
//  cls_valid   in   1          classifier valid_out
//  image_out   out  NPIX       packed binary image -> classifier image_in
//  start       out  1          one-cycle start pulse -> classifier start
//  busy        out  1          high in FIRE and WAIT
//  frame_err   out  1          one-cycle pulse on SOF received mid-frame
// BEHAVIOUR
//  Reset values: state=IDLE, image_out=0, start=0, frame_err=0, pixel count=0, threshold reg=0.
//   Because state=IDLE, pix_ready=1 and busy=0.
//  Handshake: a pixel transfers on the cycle where pix_valid&&pix_ready. pix_ready=1 in IDLE and LOAD,
//   0 in FIRE and WAIT. pix_ready is decoded combinationally from the state register only.
//  Binarisation: bit = (pix_in >= thr), unsigned compare.
//   On the SOF pixel, thr = thresh_in of the same cycle; that value is also latched for the rest of the frame.
//  Packing: raster index k = row*IMG_W + col. The pixel with index k writes image_out[k].
//   Bits not yet written keep their previous-frame value.
//  States:
//   IDLE: transfer with sof=1 -> write bit 0, count=1, latch thr, go LOAD.
//    Transfers with sof=0 are consumed and discarded; no error.
//   LOAD: transfer with sof=0 -> write bit[count], count+1.
//    Transfer with sof=1 -> frame_err=1 next cycle, write bit 0, count=1, relatch thr, stay LOAD.
//    Transfer of index NPIX-1 -> go FIRE.
//   FIRE: start=1 for exactly this cycle; go WAIT.
//   WAIT: track cls_valid with a registered copy. On a rising edge (prev=0, now=1), go IDLE.
//    A cls_valid level that is still high from the previous frame is ignored.
//  Latency: last pixel accepted in cycle N -> start=1 in cycle N+1 -> pix_ready=1 again
//   in the cycle after cls_valid rises.
//  image_out is written only in IDLE/LOAD. It is therefore stable from FIRE until the next frame's first transfer.
//  Count width: ceil(log2(NPIX+1)). The count never exceeds NPIX-1 as an index; no wrap.
//  Reset mid-frame or mid-WAIT: immediate return to reset values; any partial frame is discarded.
//  No timeout in WAIT: the loader depends on the classifier completing.
// TESTING
//  T1 Reset: assert rst_n=0 mid-LOAD (count=50) -> next edge state IDLE, pix_ready=1, image_out=0, start=0.
//  T2 Full frame: thr=128, pixels alternate 200/10 with sof on k=0, pix_valid held high.
//   -> image_out = 196'h5...5 (even bits 1), start high one cycle, cycle after k=195.
//  T3 Back-pressure: during WAIT drive pix_valid=1 -> pix_ready=0, no image_out change.
//   Raise cls_valid 0->1 -> pix_ready=1 next cycle.
//  T4 Mid-frame SOF: sof at k=0, then sof again at k=70 -> frame_err one-cycle pulse.
//   Frame completes only after 196 more pixels; start fires once.
//  T5 Threshold edge: thresh_in=100, pixels 99/100/101 -> bits 0/1/1.
//   Change thresh_in mid-frame to 255 -> binarisation unaffected.
//  T6 Stale valid: cls_valid held 1 from prior frame at FIRE -> loader stays WAIT until cls_valid drops and rises again.
//   Random gaps in pix_valid -> same image_out as gapless run.

Source files
------------

// File: rtl/image_frame_loader.sv
// image_frame_loader
//   Feeds digit_classifier. Takes a raster stream of grayscale pixels over
//   valid/ready, binarises each pixel against a per-frame threshold and packs
//   the bits into a NPIX-bit image. When a full frame has arrived it pulses
//   start for one cycle. It then holds the image and blocks new pixels until
//   the classifier raises cls_valid.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   pix_in       grayscale pixel (unsigned)
//   pix_valid    pix_in / pix_sof valid
//   pix_sof      first pixel of a frame
//   pix_ready    loader accepts a pixel this cycle (IDLE/LOAD)
//   thresh_in    threshold, sampled with the SOF pixel
//   cls_valid    classifier completion (rising edge releases WAIT)
//   image_out    packed binary image, bit k = raster index k
//   start        one-cycle classifier start
//   busy         high in FIRE and WAIT
//   frame_err    one-cycle pulse after a SOF arrives mid-frame
module image_frame_loader #(
  parameter int IMG_W    = 14,
  parameter int IMG_H    = 14,
  parameter int PIX_BITS = 8,
  localparam int NPIX    = IMG_W * IMG_H,
  localparam int CW      = $clog2(NPIX + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PIX_BITS-1:0] pix_in,
  input  logic                pix_valid,
  input  logic                pix_sof,
  output logic                pix_ready,
  input  logic [PIX_BITS-1:0] thresh_in,
  input  logic                cls_valid,
  output logic [NPIX-1:0]     image_out,
  output logic                start,
  output logic                busy,
  output logic                frame_err
);

  typedef enum logic [1:0] {IDLE, LOAD, FIRE, WAIT} state_t;

  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       count;
  logic [PIX_BITS-1:0] thr_q;
  logic                cls_prev;
  logic                xfer;
  logic [PIX_BITS-1:0] thr_eff;
  logic                pix_bit;

  assign xfer    = pix_valid && pix_ready;
  // The SOF pixel is judged against the threshold presented with it, not the
  // one latched for the previous frame.
  assign thr_eff = pix_sof ? thresh_in : thr_q;
  assign pix_bit = (pix_in >= thr_eff);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (xfer && pix_sof) state_nxt = LOAD;
      LOAD: if (xfer && !pix_sof && count == LAST) state_nxt = FIRE;
      FIRE: state_nxt = WAIT;
      // Only a fresh rising edge releases; a level left high by the previous
      // frame is ignored.
      WAIT: if (cls_valid && !cls_prev) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    pix_ready = (state == IDLE) || (state == LOAD);
    busy      = (state == FIRE) || (state == WAIT);
    start     = (state == FIRE);
  end

  // Datapath: pixel count, latched threshold, image bits, error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      thr_q     <= '0;
      image_out <= '0;
      frame_err <= 1'b0;
      cls_prev  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      cls_prev  <= cls_valid;
      if (xfer) begin
        if (pix_sof) begin
          // A SOF always restarts the frame; in LOAD it also flags an error.
          image_out[0] <= pix_bit;
          count        <= CW'(1);
          thr_q        <= thresh_in;
          frame_err    <= (state == LOAD);
        end else if (state == LOAD) begin
          image_out[count] <= pix_bit;
          count            <= (count == LAST) ? '0 : count + CW'(1);
        end
        // Non-SOF pixels in IDLE are consumed and dropped.
      end
    end
  end

endmodule

// File: tb/tb_image_frame_loader.sv
module tb_image_frame_loader;
  localparam int NPIX = 196;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      pix_in = '0;
  logic            pix_valid = 1'b0;
  logic            pix_sof = 1'b0;
  logic            pix_ready;
  logic [7:0]      thresh_in = '0;
  logic            cls_valid = 1'b0;
  logic [NPIX-1:0] image_out;
  logic            start;
  logic            busy;
  logic            frame_err;

  image_frame_loader dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .thresh_in(thresh_in),
    .cls_valid(cls_valid), .image_out(image_out), .start(start),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [NPIX-1:0] exp_q[$];
  int ferr_pend = 0;
  logic [NPIX-1:0] mdl = '0;
  logic start_prev = 1'b0;
  logic ferr_prev = 1'b0;

  task automatic chk(input string name, input logic [NPIX-1:0] act, input logic [NPIX-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every start pops the scoreboard, every frame_err consumes a
  // pending expected error.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL start_unexpected act=1 exp=0");
        end else begin
          logic [NPIX-1:0] e;
          e = exp_q.pop_front();
          checks++;
          if (image_out !== e) begin
            failures++;
            $display("FAIL sb_image act=%0h exp=%0h", image_out, e);
          end
        end
        if (start_prev) begin
          checks++; failures++;
          $display("FAIL start_width act=2+ exp=1");
        end
      end
      if (frame_err) begin
        checks++;
        if (ferr_pend == 0 || ferr_prev) begin
          failures++;
          $display("FAIL frame_err_unexpected act=1 exp=0");
        end else ferr_pend--;
      end
    end
    start_prev <= start;
    ferr_prev  <= frame_err;
  end

  function automatic logic [7:0] pix_of(input int mode, input int k);
    case (mode)
      0:       pix_of = (k % 2 == 0) ? 8'd200 : 8'd10;
      1:       pix_of = (k % 3 == 0) ? 8'd99 : ((k % 3 == 1) ? 8'd100 : 8'd101);
      default: pix_of = 8'((k * 37 + 11) & 255);
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_pix(input logic [7:0] p, input logic s, input logic [7:0] t);
    int n = 0;
    pix_in = p; pix_sof = s; thresh_in = t; pix_valid = 1'b1;
    while (!pix_ready && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) begin
      checks++; failures++;
      $display("FAIL send_timeout act=0 exp=1");
    end
    @(posedge clk); @(negedge clk);
  endtask

  // Sends n pixels of a pattern; SOF on k=0, thresh_in forced to 255 after it.
  task automatic run_frame(input int mode, input logic [7:0] thr, input bit gaps, input int n);
    for (int k = 0; k < n; k++) begin
      logic [7:0] p;
      p = pix_of(mode, k);
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      mdl[k] = (p >= thr);
      if (k == NPIX - 1) exp_q.push_back(mdl);
      send_pix(p, k == 0, (k == 0) ? thr : 8'hFF);
    end
    pix_valid = 1'b0;
    if (n == NPIX) chk("start_latency", {195'b0, start}, 1);
  endtask

  // In WAIT: pixels are refused and the image holds; a cls_valid rise releases.
  task automatic release_wait(input bit keep_high);
    pix_valid = 1'b1; pix_sof = 1'b0; pix_in = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wait_ready", {195'b0, pix_ready}, 0);
      chk("wait_image", image_out, mdl);
    end
    pix_valid = 1'b0;
    cls_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("release_ready", {195'b0, pix_ready}, 1);
    chk("release_busy", {195'b0, busy}, 0);
    if (!keep_high) cls_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NPIX-1:0] alt;
    alt = {49{4'h5}};
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {195'b0, pix_ready}, 1);
    chk("rst_busy", {195'b0, busy}, 0);
    chk("rst_image", image_out, 0);
    chk("rst_start", {195'b0, start}, 0);
    chk("rst_ferr", {195'b0, frame_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T2: alternating frame, threshold 128
    run_frame(0, 8'd128, 1'b0, NPIX);
    chk("t2_image_const", image_out, alt);
    chk("t2_busy", {195'b0, busy}, 1);
    @(negedge clk);
    chk("t2_start_low", {195'b0, start}, 0);
    // T3: back-pressure and release
    release_wait(1'b0);
    // Non-SOF pixels in IDLE are dropped without effect
    for (int i = 0; i < 3; i++) send_pix(8'd0, 1'b0, 8'd0);
    pix_valid = 1'b0;
    @(negedge clk);
    chk("idle_drop_image", image_out, alt);
    chk("idle_drop_ready", {195'b0, pix_ready}, 1);

    // T1: reset mid-LOAD at count=50
    run_frame(2, 8'd90, 1'b0, 50);
    chk("t1_busy_pre", {195'b0, busy}, 0);
    rst_n = 1'b0;
    #1;
    chk("t1_ready", {195'b0, pix_ready}, 1);
    chk("t1_image", image_out, 0);
    chk("t1_start", {195'b0, start}, 0);
    chk("t1_busy", {195'b0, busy}, 0);
    mdl = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T5: threshold boundary 99/100/101 at thr=100, thresh_in then 255
    run_frame(1, 8'd100, 1'b0, NPIX);
    chk("t5_bits", {193'b0, image_out[2:0]}, {193'b0, 3'b110});
    release_wait(1'b0);

    // T4: SOF again at k=70 -> frame_err, only one start
    run_frame(0, 8'd128, 1'b0, 70);
    ferr_pend++;
    run_frame(2, 8'd90, 1'b0, NPIX);
    release_wait(1'b0);

    // T6: gapped run yields the same image as the gapless one
    run_frame(2, 8'd90, 1'b1, NPIX);
    release_wait(1'b1);
    // T6: stale cls_valid still high at FIRE
    run_frame(0, 8'd128, 1'b0, NPIX);
    repeat (5) @(negedge clk);
    chk("stale_hold", {195'b0, pix_ready}, 0);
    cls_valid = 1'b0;
    @(negedge clk);
    chk("stale_low", {195'b0, pix_ready}, 0);
    cls_valid = 1'b1;
    @(negedge clk);
    chk("stale_rise", {195'b0, pix_ready}, 1);
    cls_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("sb_drained", 196'(exp_q.size()), 0);
    chk("ferr_drained", 196'(ferr_pend), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
